// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared binary64 constants and the comparison result flag type
package comparator_pkg;

  localparam int FP64_W = 64;
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 11'h7FF;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
    logic unord;
  } cmp_flags_t;

  function automatic logic is_nan(input logic [FP64_W-1:0] v);
    return (v[FP64_W-2 -: EXP_W] == EXP_ALL_ONES) && (v[FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp64_cmp_core.sv
// rtl/fp64_cmp_core.sv - combinational binary64 numeric compare producing eq/lt/gt/unord
module fp64_cmp_core
  import comparator_pkg::*;
(
  input  logic [FP64_W-1:0] a,
  input  logic [FP64_W-1:0] b,
  output cmp_flags_t        flags
);

  logic              a_sign;
  logic              b_sign;
  logic [FP64_W-2:0] a_mag;
  logic [FP64_W-2:0] b_mag;
  logic              any_nan;
  logic              both_zero;
  logic              mag_lt;
  logic              mag_eq;

  assign a_sign    = a[FP64_W-1];
  assign b_sign    = b[FP64_W-1];
  assign a_mag     = a[FP64_W-2:0];
  assign b_mag     = b[FP64_W-2:0];
  assign any_nan   = is_nan(a) || is_nan(b);
  assign both_zero = (a_mag == '0) && (b_mag == '0);
  assign mag_lt    = a_mag < b_mag;
  assign mag_eq    = a_mag == b_mag;

  // Sign-magnitude ordering: infinities and subnormals fall out of the magnitude compare.
  always_comb begin
    flags = '0;
    if (any_nan) begin
      flags.unord = 1'b1;
    end else if (both_zero) begin
      flags.eq = 1'b1;
    end else if (a_sign != b_sign) begin
      flags.gt = b_sign;
      flags.lt = a_sign;
    end else if (mag_eq) begin
      flags.eq = 1'b1;
    end else if (!a_sign) begin
      flags.lt = mag_lt;
      flags.gt = !mag_lt;
    end else begin
      flags.lt = !mag_lt;
      flags.gt = mag_lt;
    end
  end

endmodule

// File: rtl/comparator.sv
// rtl/comparator.sv - pipelined binary64 comparator with optional input register stage
module comparator
  import comparator_pkg::*;
#(
  parameter int REG_INPUTS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FP64_W-1:0] A_64,
  input  logic [FP64_W-1:0] B_64,
  output logic              out_valid,
  output logic              equal_to,
  output logic              less_than,
  output logic              greater_than,
  output logic              unordered
);

  logic [FP64_W-1:0] a_s;
  logic [FP64_W-1:0] b_s;
  logic              v_s;
  cmp_flags_t        core_flags;
  cmp_flags_t        flags_q;

  generate
    if (REG_INPUTS != 0) begin : g_in_reg
      logic [FP64_W-1:0] a_q;
      logic [FP64_W-1:0] b_q;
      logic              v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          v_q <= 1'b0;
        end else begin
          v_q <= in_valid;
          if (in_valid) begin
            a_q <= A_64;
            b_q <= B_64;
          end
        end
      end

      assign a_s = a_q;
      assign b_s = b_q;
      assign v_s = v_q;
    end else begin : g_no_reg
      assign a_s = A_64;
      assign b_s = B_64;
      assign v_s = in_valid;
    end
  endgenerate

  fp64_cmp_core u_core (
    .a     (a_s),
    .b     (b_s),
    .flags (core_flags)
  );

  // Flags only load on a valid beat so they hold through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      flags_q   <= '0;
    end else begin
      out_valid <= v_s;
      if (v_s) begin
        flags_q <= core_flags;
      end
    end
  end

  assign equal_to     = flags_q.eq;
  assign less_than    = flags_q.lt;
  assign greater_than = flags_q.gt;
  assign unordered    = flags_q.unord;

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - randomized and directed check of comparator at both input-register settings
module tb_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a_in;
  logic [63:0] b_in;

  logic ov0, eq0, lt0, gt0, un0;
  logic ov1, eq1, lt1, gt1, un1;

  int total = 0;
  int bad   = 0;

  // expected state: dut0 (latency 1) and dut1 (latency 2)
  logic       e0_v;
  logic [3:0] e0_f;
  logic       e1_v;
  logic [3:0] e1_f;
  logic       p1_v;
  logic [3:0] p1_f;

  always #5 clk = ~clk;

  comparator #(.REG_INPUTS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A_64(a_in), .B_64(b_in),
    .out_valid(ov0), .equal_to(eq0), .less_than(lt0), .greater_than(gt0), .unordered(un0)
  );

  comparator #(.REG_INPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A_64(a_in), .B_64(b_in),
    .out_valid(ov1), .equal_to(eq1), .less_than(lt1), .greater_than(gt1), .unordered(un1)
  );

  // Reference uses the simulator's real arithmetic; NaN compares false for every relation.
  function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b);
    real ra, rb;
    logic a_nan, b_nan;
    a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    if (a_nan || b_nan) return 4'b0001;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    return {ra == rb, ra < rb, ra > rb, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " dut0 valid"}, {3'b000, ov0}, {3'b000, e0_v});
    check({tag, " dut0 flags"}, {eq0, lt0, gt0, un0}, e0_f);
    check({tag, " dut1 valid"}, {3'b000, ov1}, {3'b000, e1_v});
    check({tag, " dut1 flags"}, {eq1, lt1, gt1, un1}, e1_f);
  endtask

  // Called just after a rising edge; applies inputs, advances one edge, checks both DUTs.
  task automatic step(input string tag, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic [3:0] expf);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
    e0_v = v;
    if (v) e0_f = expf;
    e1_v = p1_v;
    if (p1_v) e1_f = p1_f;
    p1_v = v;
    p1_f = expf;
    check_all(tag);
  endtask

  task automatic model_reset();
    e0_v = 1'b0; e0_f = 4'b0000;
    e1_v = 1'b0; e1_f = 4'b0000;
    p1_v = 1'b0; p1_f = 4'b0000;
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    logic [51:0] frac;
    r    = {$urandom, $urandom};
    frac = r[51:0];
    case ($urandom_range(0, 7))
      0: return r;
      1: return {r[63], 11'h7FF, frac | 52'd1};
      2: return {r[63], 11'h7FF, 52'd0};
      3: return {r[63], 63'd0};
      4: return {r[63], 11'h000, frac};
      5: return {r[63], 11'h3FF, 44'd0, frac[7:0]};
      6: return {r[63], 11'h7FE, 52'hFFFFFFFFFFFFF};
      default: return {r[63], 11'h400, frac};
    endcase
  endfunction

  localparam logic [63:0] P54  = 64'h401599999999999A;
  localparam logic [63:0] P72  = 64'h401CCCCCCCCCCCCD;
  localparam logic [63:0] P63  = 64'h4019333333333333;
  localparam logic [63:0] P81  = 64'h4020333333333333;
  localparam logic [63:0] P90  = 64'h4022000000000000;
  localparam logic [63:0] SGN  = 64'h8000000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] PMAX = 64'h7FEFFFFFFFFFFFFF;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] ONE  = 64'h3FF0000000000000;

  localparam logic [3:0] F_EQ = 4'b1000;
  localparam logic [3:0] F_LT = 4'b0100;
  localparam logic [3:0] F_GT = 4'b0010;
  localparam logic [3:0] F_UN = 4'b0001;

  initial begin
    logic [63:0] ra, rb;
    rst      = 1'b1;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset state");
    rst = 1'b0;

    step("eq 5.4",        1'b1, P54, P54, F_EQ);
    step("eq -5.4",       1'b1, P54 | SGN, P54 | SGN, F_EQ);
    step("gt 7.2/6.3",    1'b1, P72, P63, F_GT);
    step("gt -6.3/-7.2",  1'b1, P63 | SGN, P72 | SGN, F_GT);
    step("lt 8.1/9.0",    1'b1, P81, P90, F_LT);
    step("lt -9.0/-8.1",  1'b1, P90 | SGN, P81 | SGN, F_LT);
    step("eq +0/-0",      1'b1, 64'd0, SGN, F_EQ);
    step("gt inf/max",    1'b1, PINF, PMAX, F_GT);
    step("un nan/1.0",    1'b1, QNAN, ONE, F_UN);
    step("un nan/nan",    1'b1, QNAN, QNAN, F_UN);
    step("lt -1/+0",      1'b1, ONE | SGN, 64'd0, F_LT);
    step("un snan/1.0",   1'b1, 64'h7FF0000000000001, ONE, F_UN);
    step("idle hold a",   1'b0, P72, P63, F_GT);
    step("idle hold b",   1'b0, P72, P63, F_GT);
    step("lt -inf/sub",   1'b1, PINF | SGN, 64'h0000000000000001, F_LT);
    step("gt sub/sub",    1'b1, 64'h0000000000000002, 64'h0000000000000001, F_GT);
    step("idle",          1'b0, 64'd0, 64'd0, F_EQ);

    for (int i = 0; i < 4; i++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 3) == 0) ? ra : rand_op();
      step("stream4", 1'b1, ra, rb, ref_flags(ra, rb));
    end

    for (int i = 0; i < 300; i++) begin
      ra = rand_op();
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = ra ^ SGN;
        2: rb = ra + 64'd1;
        default: rb = rand_op();
      endcase
      step("random", ($urandom_range(0, 4) != 0), ra, rb, ref_flags(ra, rb));
    end

    // Reset one cycle after a valid beat: dut1 still has it in flight.
    step("pre-reset", 1'b1, P72, P63, F_GT);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async reset");
    @(posedge clk);
    #1;
    check_all("reset held");
    rst = 1'b0;
    step("post-reset a", 1'b0, 64'd0, 64'd0, F_EQ);
    step("post-reset b", 1'b0, 64'd0, 64'd0, F_EQ);
    step("first after reset", 1'b1, P81, P90, F_LT);
    step("drain", 1'b0, 64'd0, 64'd0, F_EQ);
    step("drain2", 1'b0, 64'd0, 64'd0, F_EQ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
